// File: rtl/pht_update_sequencer.sv
// Bimodal PHT write-side front end: sweeps every counter to weakly-taken after reset,
// then queues resolved-branch counter updates in order and drains them bank-conflict free.
module pht_update_sequencer #(
  parameter int IN_WIDTH            = 2,
  parameter int OUT_WIDTH           = 2,
  parameter int QUEUE_DEPTH         = 8,
  parameter int INDEX_WIDTH         = 10,
  parameter int CTR_WIDTH           = 2,
  parameter int BANK_BIT_WIDTH      = 1,
  parameter int PC_WIDTH            = 32,
  parameter int INSN_ADDR_BIT_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rstN,
  input  logic [IN_WIDTH-1:0]               inValid,
  input  logic [IN_WIDTH*PC_WIDTH-1:0]      inPC,
  input  logic [IN_WIDTH-1:0]               inTaken,
  input  logic [IN_WIDTH*CTR_WIDTH-1:0]     inPrevCtr,
  output logic                              inReady,
  output logic [OUT_WIDTH-1:0]              outWE,
  output logic [OUT_WIDTH*INDEX_WIDTH-1:0]  outWA,
  output logic [OUT_WIDTH*CTR_WIDTH-1:0]    outWV,
  output logic                              initDone,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]  count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] wa;
    logic [CTR_WIDTH-1:0]   wv;
  } entry_t;

  state_e                 r_state;
  logic [INDEX_WIDTH-1:0] r_init_idx;
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;
  entry_t                 r_mem [QUEUE_DEPTH];

  logic [CTR_WIDTH-1:0]   w_prev     [IN_WIDTH];
  entry_t                 w_lane     [IN_WIDTH];
  logic [CNT_W-1:0]       w_lane_off [IN_WIDTH];
  logic [CNT_W-1:0]       w_enq_num;
  logic [CNT_W-1:0]       w_enq_cnt;
  logic                   w_enq_fire;

  entry_t                 w_head_ent [OUT_WIDTH];
  logic [OUT_WIDTH-1:0]   w_emit;
  logic [CNT_W-1:0]       w_deq_num;
  logic                   w_blocked;
  logic                   w_unused;

  // Per-lane entry build and compaction offsets (valid lanes packed in lane order).
  always_comb begin
    // NOTE: every variable gets a default before any conditional path, so no latch is inferred.
    w_enq_num = '0;
    for (int l = 0; l < IN_WIDTH; l++) begin
      w_prev[l]    = inPrevCtr[l*CTR_WIDTH +: CTR_WIDTH];
      w_lane[l].wa = inPC[l*PC_WIDTH + INSN_ADDR_BIT_WIDTH +: INDEX_WIDTH];
      if (inTaken[l]) begin
        w_lane[l].wv = (w_prev[l] == CTR_MAX) ? CTR_MAX : w_prev[l] + CTR_WIDTH'(1);
      end else begin
        w_lane[l].wv = (w_prev[l] == '0) ? '0 : w_prev[l] - CTR_WIDTH'(1);
      end
      w_lane_off[l] = w_enq_num;
      // NOTE: blocking accumulation is intended here; each lane sees the count of lanes before it.
      if (inValid[l]) begin
        w_enq_num = w_enq_num + CNT_W'(1);
      end
    end
  end

  assign inReady    = (r_state == ST_RUN) && (r_count <= CNT_W'(QUEUE_DEPTH - IN_WIDTH));
  assign w_enq_fire = inReady;
  assign w_enq_cnt  = w_enq_fire ? w_enq_num : '0;
  assign initDone   = (r_state == ST_RUN);
  assign count      = r_count;
  assign w_unused   = ^inPC;

  // Head-of-queue emission: in order, stopping at the first bank already used this cycle.
  always_comb begin
    w_emit    = '0;
    w_deq_num = '0;
    w_blocked = 1'b0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      w_head_ent[k] = r_mem[r_head + PTR_W'(k)];
      if ((r_state == ST_RUN) && !w_blocked && (CNT_W'(k) < r_count)) begin
        for (int j = 0; j < k; j++) begin
          if (w_head_ent[j].wa[BANK_BIT_WIDTH-1:0] == w_head_ent[k].wa[BANK_BIT_WIDTH-1:0]) begin
            w_blocked = 1'b1;
          end
        end
        if (!w_blocked) begin
          w_emit[k] = 1'b1;
          w_deq_num = w_deq_num + CNT_W'(1);
        end
      end else begin
        w_blocked = 1'b1;
      end
    end
  end

  always_comb begin
    outWE = '0;
    outWA = '0;
    outWV = '0;
    if (r_state == ST_INIT) begin
      outWE[0]                = 1'b1;
      outWA[INDEX_WIDTH-1:0]  = r_init_idx;
      outWV[CTR_WIDTH-1:0]    = CTR_WEAK;
    end else begin
      for (int k = 0; k < OUT_WIDTH; k++) begin
        outWE[k]                               = w_emit[k];
        outWA[k*INDEX_WIDTH +: INDEX_WIDTH]    = w_head_ent[k].wa;
        outWV[k*CTR_WIDTH +: CTR_WIDTH]        = w_head_ent[k].wv;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= ST_IDLE;
      r_init_idx <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_INIT;
        ST_INIT: begin
          r_init_idx <= r_init_idx + INDEX_WIDTH'(1);
          if (r_init_idx == '1) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_head  <= r_head + PTR_W'(w_deq_num);
          r_tail  <= r_tail + PTR_W'(w_enq_cnt);
          r_count <= r_count + w_enq_cnt - w_deq_num;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: queue storage is not reset; head, tail and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      for (int l = 0; l < IN_WIDTH; l++) begin
        if (inValid[l]) begin
          r_mem[r_tail + PTR_W'(w_lane_off[l])] <= w_lane[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_pht_update_sequencer.sv
// Self-checking bench for pht_update_sequencer: init sweep, saturation table, bank
// conflicts, full queue, wrap, async reset mid-run, against a queue-based reference model.
module tb_pht_update_sequencer;

  localparam int IW = 4;
  localparam int QD = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  inValid;
  logic [63:0] inPC;
  logic [1:0]  inTaken;
  logic [3:0]  inPrevCtr;
  logic        inReady;
  logic [1:0]  outWE;
  logic [2*IW-1:0] outWA;
  logic [3:0]  outWV;
  logic        initDone;
  logic [3:0]  count;

  always #5 clk = ~clk;

  pht_update_sequencer #(.INDEX_WIDTH(IW), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inPC(inPC), .inTaken(inTaken),
    .inPrevCtr(inPrevCtr), .inReady(inReady), .outWE(outWE), .outWA(outWA),
    .outWV(outWV), .initDone(initDone), .count(count)
  );

  typedef struct { int wa; int wv; } upd_t;
  typedef struct { int prev; bit taken; int exp_wv; } sat_vec_t;

  upd_t     mq[$];
  upd_t     in_log[$];
  upd_t     out_log[$];
  sat_vec_t sv[8];
  int       total = 0;
  int       bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  function automatic int next_ctr(input int prev, input bit taken);
    if (taken) return (prev + 1 > 3) ? 3 : prev + 1;
    return (prev - 1 < 0) ? 0 : prev - 1;
  endfunction

  function automatic int pc_idx(input logic [31:0] pc);
    return int'(pc >> 2) % (1 << IW);
  endfunction

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] tk, input logic [3:0] pr, output bit accepted);
    int  n;
    bit  bank_used[2];
    bit  exp_rdy;
    upd_t u;
    inValid   = v;
    inPC      = {p1, p0};
    inTaken   = tk;
    inPrevCtr = pr;
    #1;
    exp_rdy = (QD - mq.size() >= 2);
    check("ready", inReady, exp_rdy);
    check("count", count, mq.size());
    n = 0;
    bank_used = '{0, 0};
    while (n < 2 && n < mq.size() && !bank_used[mq[n].wa % 2]) begin
      bank_used[mq[n].wa % 2] = 1'b1;
      n++;
    end
    check("we", outWE, (1 << n) - 1);
    for (int k = 0; k < n; k++) begin
      check("wa", outWA[k*IW +: IW], mq[k].wa);
      check("wv", outWV[k*2 +: 2], mq[k].wv);
    end
    for (int k = 0; k < 2; k++) begin
      if (outWE[k]) begin
        u.wa = int'(outWA[k*IW +: IW]);
        u.wv = int'(outWV[k*2 +: 2]);
        out_log.push_back(u);
      end
    end
    repeat (n) void'(mq.pop_front());
    if (exp_rdy) begin
      for (int l = 0; l < 2; l++) begin
        if (v[l]) begin
          u.wa = pc_idx(l == 0 ? p0 : p1);
          u.wv = next_ctr(int'(pr[l*2 +: 2]), tk[l]);
          mq.push_back(u);
          in_log.push_back(u);
        end
      end
    end
    accepted = exp_rdy;
    @(negedge clk);
  endtask

  // Entered just after rstN rises between edges.
  task automatic init_check();
    #1;
    check("idle_we", outWE, 0);
    check("idle_done", initDone, 0);
    check("idle_ready", inReady, 0);
    for (int i = 0; i < (1 << IW); i++) begin
      @(negedge clk); #1;
      check("init_we", outWE, 2'b01);
      check("init_wa", outWA[IW-1:0], i);
      check("init_wv", outWV[1:0], 2);
      check("init_ready", inReady, 0);
      check("init_done", initDone, 0);
    end
    @(negedge clk); #1;
    check("run_done", initDone, 1);
    check("run_ready", inReady, 1);
    check("run_we", outWE, 0);
    check("run_count", count, 0);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 40 && mq.size() > 0; i++) step(2'b00, 0, 0, 0, 0, acc);
    #1;
    check("drain_count", count, 0);
    check("drain_we", outWE, 0);
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_len"}, out_log.size(), in_log.size());
    for (int i = 0; i < in_log.size() && i < out_log.size(); i++) begin
      check({tag, "_ord_wa"}, out_log[i].wa, in_log[i].wa);
      check({tag, "_ord_wv"}, out_log[i].wv, in_log[i].wv);
    end
    in_log.delete();
    out_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          peak;
    logic [1:0]  v, tk;
    logic [31:0] p0, p1;
    logic [3:0]  pr;

    sv[0] = '{3, 1'b1, 3};
    sv[1] = '{0, 1'b0, 0};
    sv[2] = '{1, 1'b1, 2};
    sv[3] = '{2, 1'b0, 1};
    sv[4] = '{0, 1'b1, 1};
    sv[5] = '{3, 1'b0, 2};
    sv[6] = '{2, 1'b1, 3};
    sv[7] = '{1, 1'b0, 0};

    rstN = 1'b0; inValid = '0; inPC = '0; inTaken = '0; inPrevCtr = '0;
    #1;
    check("rst_we", outWE, 0);
    check("rst_ready", inReady, 0);
    check("rst_done", initDone, 0);
    check("rst_count", count, 0);
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;
    init_check();

    // Saturation table, one update at a time on lane 0.
    for (int i = 0; i < 8; i++) begin
      step(2'b01, 32'h100 + 32'(i * 4), 0, {1'b0, sv[i].taken}, {2'b00, 2'(sv[i].prev)}, acc);
      inValid = 2'b00;
      #1;
      check("sat_we", outWE[0], 1);
      check("sat_wv", outWV[1:0], sv[i].exp_wv);
      step(2'b00, 0, 0, 0, 0, acc);
    end

    // Different banks leave together; same bank leaves on port 0 in consecutive cycles.
    step(2'b11, 32'h100, 32'h104, 2'b00, 4'b0000, acc);
    inValid = 2'b00;
    #1;
    check("t3_both_we", outWE, 2'b11);
    check("t3_p0_wa", outWA[IW-1:0], pc_idx(32'h100));
    check("t3_p1_wa", outWA[2*IW-1:IW], pc_idx(32'h104));
    step(2'b00, 0, 0, 0, 0, acc);
    step(2'b11, 32'h100, 32'h108, 2'b11, 4'b0101, acc);
    inValid = 2'b00;
    #1;
    check("t3_conf_we0", outWE, 2'b01);
    check("t3_conf_wa0", outWA[IW-1:0], pc_idx(32'h100));
    step(2'b00, 0, 0, 0, 0, acc);
    #1;
    check("t3_conf_we1", outWE, 2'b01);
    check("t3_conf_wa1", outWA[IW-1:0], pc_idx(32'h108));
    check("t3_conf_wv1", outWV[1:0], 2);
    drain();
    compare_logs("t2t3");

    // Full queue: two bank-0 updates offered every cycle, one drained per cycle.
    peak = 0;
    acc = 1'b1;
    p0 = 32'h200;
    for (int c = 0; c < 14; c++) begin
      if (acc) p0 = p0 + 32'h10;
      #1;
      if (int'(count) > peak) peak = int'(count);
      step(2'b11, p0, p0 + 32'h8, c[1:0], {c[3:2], c[1:0]}, acc);
    end
    check("t4_peak", peak >= 7, 1);
    drain();
    compare_logs("t4");

    // Random mixed traffic, long enough to wrap the pointers several times.
    acc = 1'b1;
    v = '0; p0 = '0; p1 = '0; tk = '0; pr = '0;
    for (int c = 0; c < 40; c++) begin
      if (acc) begin
        v = 2'($urandom); p0 = $urandom; p1 = $urandom;
        tk = 2'($urandom); pr = 4'($urandom);
      end
      step(v, p0, p1, tk, pr, acc);
    end
    drain();
    compare_logs("t5");

    // Async reset with five entries queued.
    for (int i = 0; i < 10 && mq.size() != 5; i++) begin
      step(2'b11, 32'h300 + 32'(i * 16), 32'h308 + 32'(i * 16), 2'b10, 4'b0110, acc);
    end
    #2;
    rstN = 1'b0;
    #1;
    check("t6_we", outWE, 0);
    check("t6_count", count, 0);
    check("t6_ready", inReady, 0);
    check("t6_done", initDone, 0);
    mq.delete();
    in_log.delete();
    out_log.delete();
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;
    init_check();
    for (int i = 0; i < 3; i++) step(2'b00, 0, 0, 0, 0, acc);
    acc = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (acc) begin
        v = 2'($urandom); p0 = $urandom; p1 = $urandom;
        tk = 2'($urandom); pr = 4'($urandom);
      end
      step(v, p0, p1, tk, pr, acc);
    end
    drain();
    compare_logs("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
